vga_timing_gen_win: RTL

- Parametrised, next-generation VGA/DVI timing generator for any resolution.
- Produces hsync, vsync, blank_n and de, with selectable sync polarity and a configurable pipeline delay that aligns the syncs with frame-buffer read data.
- Generates a parametrised read window inside the active area: rd_req plus window-relative rd_x/rd_y, frame_start and line_start strobes.
- Sits between the pixel clock domain and the frame-buffer FIFO read port.

---
 rtl/vga_timing_gen_win_if.sv | 32 +++
 rtl/vga_timing_gen_win.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_win_if.sv
// vga_timing_gen_win_if: video timing and frame-buffer read-window bundle.
//   master (timing generator) drives, slave (display / FIFO side) observes:
//     hsync, vsync      - sync pulses, polarity set by the generator
//     blank_n, de       - high inside the active area (de is a DVI copy)
//     rd_req            - frame-buffer read request inside the read window
//     rd_x, rd_y        - window-relative coordinate of the current rd_req
//     frame_start       - one-cycle pulse at h=0, v=0
//     line_start        - one-cycle pulse at h=0
// None of these carry valid/ready semantics: every signal is a registered,
// free-running strobe or level; the consumer cannot stall the generator.
`timescale 1ns/1ps
interface vga_timing_gen_win_if #(
  parameter int CW = 12
);
  logic          hsync;
  logic          vsync;
  logic          blank_n;
  logic          de;
  logic          rd_req;
  logic [CW-1:0] rd_x;
  logic [CW-1:0] rd_y;
  logic          frame_start;
  logic          line_start;

  modport master (
    output hsync, vsync, blank_n, de, rd_req, rd_x, rd_y, frame_start, line_start
  );

  modport slave (
    input hsync, vsync, blank_n, de, rd_req, rd_x, rd_y, frame_start, line_start
  );
endinterface

// File: rtl/vga_timing_gen_win.sv
// vga_timing_gen_win: parametrised VGA/DVI timing generator with a read
// window inside the active area.
//   pixel_clk  - pixel clock
//   nreset     - synchronous reset, active-high (despite the name)
//   enable     - counting enable; 0 freezes counters and the alignment pipe
//   ext_vsync  - genlock input (only with VGA_TIMING_GENLOCK_EN defined)
//   vid        - vga_timing_gen_win_if.master: syncs, blank/de, read window
// Optional feature macro: VGA_TIMING_GENLOCK_EN (external vsync genlock).
// Latency: rd_req/rd_x/rd_y/frame_start/line_start are 1 cycle after the
// count; hsync/vsync/blank_n/de are 1+PIPE_DLY cycles after the count.
`timescale 1ns/1ps
module vga_timing_gen_win #(
  parameter int CW       = 12,
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int WIN_X0   = 192,
  parameter int WIN_Y0   = 128,
  parameter int WIN_W    = 640,
  parameter int WIN_H    = 512,
  parameter int PIPE_DLY = 2
) (
  input  logic                 pixel_clk,
  input  logic                 nreset,
  input  logic                 enable,
`ifdef VGA_TIMING_GENLOCK_EN
  input  logic                 ext_vsync,
`endif
  vga_timing_gen_win_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Window edges clipped to the active area so oversized windows stay legal.
  localparam int WX0_I = (WIN_X0 > H_ACTIVE) ? H_ACTIVE : WIN_X0;
  localparam int WY0_I = (WIN_Y0 > V_ACTIVE) ? V_ACTIVE : WIN_Y0;
  localparam int WX1_I = (WIN_X0 + WIN_W > H_ACTIVE) ? H_ACTIVE : WIN_X0 + WIN_W;
  localparam int WY1_I = (WIN_Y0 + WIN_H > V_ACTIVE) ? V_ACTIVE : WIN_Y0 + WIN_H;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] WX0      = CW'(WX0_I);
  localparam logic [CW-1:0] WY0      = CW'(WY0_I);
  localparam logic [CW-1:0] WX1      = CW'(WX1_I);
  localparam logic [CW-1:0] WY1      = CW'(WY1_I);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  generate
    if ((H_TOTAL - 1 >= (1 << CW)) || (V_TOTAL - 1 >= (1 << CW))) begin : g_bad_cw
      $error("vga_timing_gen_win: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
    end
    if ((PIPE_DLY < 0) || (PIPE_DLY > 15)) begin : g_bad_dly
      $error("vga_timing_gen_win: PIPE_DLY must be 0..15");
    end
  endgenerate

  // Genlock: restart strobe from a synchronised rising edge of ext_vsync.
  logic gl_restart;
`ifdef VGA_TIMING_GENLOCK_EN
  logic [2:0] ext_sync; // [0],[1] synchroniser, [2] edge history
  always_ff @(posedge pixel_clk) begin
    if (nreset) ext_sync <= '0;
    else        ext_sync <= {ext_sync[1:0], ext_vsync};
  end
  assign gl_restart = ext_sync[1] & ~ext_sync[2];
`else
  assign gl_restart = 1'b0;
`endif

  // Raster counters.
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge pixel_clk) begin
    if (nreset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (enable) begin
      if (gl_restart) begin
        // Forcing (0,0) is idempotent with a natural wrap, so no double pulse.
        h_cnt <= '0;
        v_cnt <= '0;
      end else begin
        h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
        if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end
    end
  end

  // Decode of the current count.
  logic hs_raw, vs_raw, act, in_win;
  assign hs_raw = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_raw = (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign act    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign in_win = act && (h_cnt >= WX0) && (h_cnt < WX1) &&
                  (v_cnt >= WY0) && (v_cnt < WY1);

  // Decode register: one cycle after the count.
  logic          hs_d, vs_d, act_d;
  logic          rd_req_q, fs_q, ls_q;
  logic [CW-1:0] rd_x_q, rd_y_q;

  always_ff @(posedge pixel_clk) begin
    if (nreset) begin
      hs_d     <= ~HS_ON;
      vs_d     <= ~VS_ON;
      act_d    <= 1'b0;
      rd_req_q <= 1'b0;
      rd_x_q   <= '0;
      rd_y_q   <= '0;
      fs_q     <= 1'b0;
      ls_q     <= 1'b0;
    end else if (enable) begin
      hs_d     <= hs_raw ? HS_ON : ~HS_ON;
      vs_d     <= vs_raw ? VS_ON : ~VS_ON;
      act_d    <= act;
      rd_req_q <= in_win;
      if (in_win) begin
        rd_x_q <= h_cnt - WX0;
        rd_y_q <= v_cnt - WY0;
      end
      fs_q     <= (h_cnt == '0) && (v_cnt == '0);
      ls_q     <= (h_cnt == '0);
    end else begin
      // Strobes must not repeat while the raster is frozen.
      rd_req_q <= 1'b0;
      fs_q     <= 1'b0;
      ls_q     <= 1'b0;
    end
  end

  // Alignment pipe for the sync/blank group only.
  logic hs_o, vs_o, act_o;
  generate
    if (PIPE_DLY == 0) begin : g_no_pipe
      assign hs_o  = hs_d;
      assign vs_o  = vs_d;
      assign act_o = act_d;
    end else begin : g_pipe
      logic [2:0] pipe_q [PIPE_DLY];
      always_ff @(posedge pixel_clk) begin
        if (nreset) begin
          for (int i = 0; i < PIPE_DLY; i++) pipe_q[i] <= {~HS_ON, ~VS_ON, 1'b0};
        end else if (enable) begin
          pipe_q[0] <= {hs_d, vs_d, act_d};
          for (int i = 1; i < PIPE_DLY; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign {hs_o, vs_o, act_o} = pipe_q[PIPE_DLY-1];
    end
  endgenerate

  assign vid.hsync       = hs_o;
  assign vid.vsync       = vs_o;
  assign vid.blank_n     = act_o;
  assign vid.de          = act_o;
  assign vid.rd_req      = rd_req_q;
  assign vid.rd_x        = rd_x_q;
  assign vid.rd_y        = rd_y_q;
  assign vid.frame_start = fs_q;
  assign vid.line_start  = ls_q;

endmodule
